// File: rtl/approx_mul_ha_pipe.sv
// Streaming unsigned WIDTHxWIDTH multiplier built from half-adder row-pair arrays.
// Array 0 can drop carries in selected columns (OR-only sums) per transaction.
// Three registered stages: HA arrays -> pairwise array sums -> final product.
module approx_mul_ha_pipe #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-2:0] APPROX_MASK = 7'b0010111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               p_approx
);

  localparam int unsigned NARR  = WIDTH / 2;
  localparam int unsigned NPAIR = (NARR + 1) / 2;
  // Array count rounded up to a whole number of pairs; padded arrays see zero rows.
  localparam int unsigned NPAD  = 2 * NPAIR;
  localparam int unsigned PW    = 2 * WIDTH;

  logic [2*NPAD-1:0] x_pad;
  logic              stall;

  logic [WIDTH:0]    t_d [NPAD];
  logic [WIDTH-2:0]  b_d [NPAD];
  logic [WIDTH:0]    t_q [NPAD];
  logic [WIDTH-2:0]  b_q [NPAD];
  logic              ap1_q, v1_q;

  logic [PW-1:0]     s2_d [NPAIR];
  logic [PW-1:0]     s2_q [NPAIR];
  logic              ap2_q, v2_q;

  logic [PW-1:0]     p_d;
  logic [PW-1:0]     p_q;
  logic              ap3_q, v3_q;

  logic              a_b, c_b, s_b, cy_b;

  assign x_pad     = (2*NPAD)'(x);
  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign p         = p_q;
  assign p_approx  = ap3_q;

  // Value of one array: sum bits at weight 2^i, carry bits at weight 2^(j+2).
  function automatic logic [PW-1:0] arr_val(input logic [WIDTH:0] t, input logic [WIDTH-2:0] b);
    return {{(WIDTH-1){1'b0}}, t} + {{(WIDTH-1){1'b0}}, b, 2'b00};
  endfunction

  // Half-adder arrays for every row pair; masked columns of array 0 go OR-only when approximating.
  always_comb begin
    a_b  = 1'b0;
    c_b  = 1'b0;
    s_b  = 1'b0;
    cy_b = 1'b0;
    for (int k = 0; k < NPAD; k++) begin
      t_d[k]    = '0;
      b_d[k]    = '0;
      t_d[k][0] = y[0] & x_pad[2*k];
      for (int i = 1; i < WIDTH; i++) begin
        a_b = y[i] & x_pad[2*k];
        c_b = y[i-1] & x_pad[2*k+1];
        if (k == 0 && approx_en && APPROX_MASK[i-1]) begin
          s_b  = a_b | c_b;
          cy_b = 1'b0;
        end else begin
          s_b  = a_b ^ c_b;
          cy_b = a_b & c_b;
        end
        t_d[k][i] = s_b;
        if (i < WIDTH - 1) b_d[k][i-1] = cy_b;
        else               t_d[k][WIDTH] = cy_b;
      end
      b_d[k][WIDTH-2] = y[WIDTH-1] & x_pad[2*k+1];
    end
  end

  // Stage-2 next state: each pair of arrays shifted to its row weight and summed.
  always_comb begin
    for (int m = 0; m < NPAIR; m++) begin
      s2_d[m] = (arr_val(t_q[2*m], b_q[2*m]) << (4*m))
              + (arr_val(t_q[2*m+1], b_q[2*m+1]) << (4*m+2));
    end
  end

  // Stage-3 next state: accumulate the pair sums into the full product.
  always_comb begin
    p_d = '0;
    for (int m = 0; m < NPAIR; m++) begin
      p_d = p_d + s2_q[m];
    end
  end

  // Pipeline registers; everything holds on stall, data only loads behind a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPAD; k++) begin
        t_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int m = 0; m < NPAIR; m++) begin
        s2_q[m] <= '0;
      end
      ap1_q <= 1'b0;
      ap2_q <= 1'b0;
      ap3_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      p_q   <= '0;
    end else if (!stall) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        for (int k = 0; k < NPAD; k++) begin
          t_q[k] <= t_d[k];
          b_q[k] <= b_d[k];
        end
        ap1_q <= approx_en;
      end
      if (v1_q) begin
        for (int m = 0; m < NPAIR; m++) begin
          s2_q[m] <= s2_d[m];
        end
        ap2_q <= ap1_q;
      end
      if (v2_q) begin
        p_q   <= p_d;
        ap3_q <= ap2_q;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Scoreboard bench: expected {p_approx, p} queued on accept, compared on output.
// A second instance (WIDTH=4, mask 3'b001) covers exhaustive exact and approx pairs.
module tb_approx_mul_ha_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, approx_en, out_valid, out_ready, p_approx;
  logic [7:0]  x, y;
  logic [15:0] p;

  logic        in_valid4, in_ready4, approx_en4, out_valid4, out_ready4, p_approx4;
  logic [3:0]  x4, y4;
  logic [7:0]  p4;

  always #5 clk = ~clk;

  approx_mul_ha_pipe #(.WIDTH(8), .APPROX_MASK(7'b0010111)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .p(p),
    .p_approx(p_approx)
  );

  approx_mul_ha_pipe #(.WIDTH(4), .APPROX_MASK(3'b001)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .x(x4), .y(y4),
    .approx_en(approx_en4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4),
    .p_approx(p_approx4)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_out4 = 0;
  bit          chk_lat = 1'b0;
  bit          rnd_on = 1'b0;
  bit          held_pend = 1'b0;
  logic [16:0] held_v;
  logic [16:0] exp_cur;
  logic [16:0] e_v;
  int          a_v;
  logic [16:0] sb[$];
  int          lat_q[$];
  logic [16:0] exp4_cur;
  logic [16:0] e4;
  logic [16:0] sb4[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference for approximate mode: a masked column loses 2^i whenever both HA inputs are 1.
  function automatic int unsigned model(input int unsigned xv, input int unsigned yv,
                                        input bit ap, input int unsigned mask, input int w);
    int unsigned r = xv * yv;
    if (ap) begin
      for (int i = 1; i < w; i++) begin
        if (((mask >> (i-1)) & 1) == 1 && ((yv >> i) & 1) == 1 && (xv & 1) == 1 &&
            ((yv >> (i-1)) & 1) == 1 && ((xv >> 1) & 1) == 1)
          r = r - (1 << i);
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Main-instance monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_pend = 1'b0;
    end else begin
      if (held_pend) begin
        chk("hold_p", 32'(p), 32'(held_v[15:0]));
        chk("hold_p_approx", 32'(p_approx), 32'(held_v[16]));
      end
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      held_pend = out_valid && !out_ready;
      held_v    = {p_approx, p};
      if (in_valid && in_ready) begin
        sb.push_back(exp_cur);
        lat_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(p), 32'hFFFF_FFFF);
        end else begin
          e_v = sb.pop_front();
          a_v = lat_q.pop_front();
          chk("p", 32'(p), 32'(e_v[15:0]));
          chk("p_approx", 32'(p_approx), 32'(e_v[16]));
          if (chk_lat) chk("latency", 32'(cyc - a_v), 32'd3);
        end
      end
    end
  end

  // WIDTH=4 monitor; entry = {approx, exact product, expected product}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid4 && in_ready4) sb4.push_back(exp4_cur);
      if (out_valid4 && out_ready4) begin
        n_out4++;
        if (sb4.size() == 0) begin
          chk("w4_spurious_out", 32'(p4), 32'hFFFF_FFFF);
        end else begin
          e4 = sb4.pop_front();
          chk("w4_p", 32'(p4), 32'(e4[7:0]));
          chk("w4_p_approx", 32'(p_approx4), 32'(e4[16]));
          if (e4[16]) chk("w4_le", 32'(p4 <= e4[15:8]), 32'd1);
        end
      end
    end
  end

  // Present one transaction and hold it until the handshake edge.
  task automatic send(input int unsigned xa, input int unsigned ya, input bit ap,
                      input logic [16:0] e);
    int n = 0;
    x         = xa[7:0];
    y         = ya[7:0];
    approx_en = ap;
    exp_cur   = e;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned xr, yr, pr;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    x          = '0;
    y          = '0;
    approx_en  = 1'b0;
    out_ready  = 1'b1;
    exp_cur    = '0;
    in_valid4  = 1'b0;
    x4         = '0;
    y4         = '0;
    approx_en4 = 1'b0;
    out_ready4 = 1'b1;
    exp4_cur   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_p_approx", 32'(p_approx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner values with latency check.
    chk_lat = 1'b1;
    send(255, 255, 1'b0, {1'b0, 16'd65025});
    send(255, 255, 1'b1, {1'b1, 16'd64979});
    send(3, 3, 1'b1, {1'b1, 16'd7});
    send(3, 3, 1'b0, {1'b0, 16'd9});
    drain();

    // Random exact stream under random backpressure.
    chk_lat = 1'b0;
    rnd_on  = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          xr = $urandom_range(0, 255);
          yr = $urandom_range(0, 255);
          pr = xr * yr;
          send(xr, yr, 1'b0, {1'b0, pr[15:0]});
        end
        rnd_on = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with three transactions in flight flushes everything.
    chk_lat = 1'b1;
    send(100, 200, 1'b0, {1'b0, 16'd20000});
    send(77, 99, 1'b0, {1'b0, 16'd7623});
    send(250, 3, 1'b0, {1'b0, 16'd750});
    #1;
    rst_n = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_p", 32'(p), 32'd0);
    sb.delete();
    lat_q.delete();
    n_out = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(10, 12, 1'b0, {1'b0, 16'd120});
    repeat (10) @(posedge clk);
    #1;
    chk("flush_single_out", 32'(n_out), 32'd1);
    chk("flush_sb_empty", 32'(sb.size()), 32'd0);

    // WIDTH=4 instance: exhaustive exact, then exhaustive approximate.
    for (int ap = 0; ap < 2; ap++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          pr         = model(a, b, ap[0], 32'd1, 4);
          xr         = a * b;
          x4         = a[3:0];
          y4         = b[3:0];
          approx_en4 = ap[0];
          exp4_cur   = {ap[0], xr[7:0], pr[7:0]};
          in_valid4  = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
    x4         = 4'd3;
    y4         = 4'd1;
    approx_en4 = 1'b1;
    exp4_cur   = {1'b1, 8'd3, 8'd3};
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("w4_out_count", 32'(n_out4), 32'd513);
    chk("w4_sb_empty", 32'(sb4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_mul_ha_pipe.md
Name: approx_mul_ha_pipe

Overview:
- Parametrised, pipelined unsigned WIDTHxWIDTH multiplier built from per-row-pair half-adder arrays.
- Array 0 optionally replaces selected half-adder columns with OR-only sums (approximate mode, selectable per transaction).
- The arrays are reduced and accumulated over a 3-stage valid/ready pipeline into a 2*WIDTH product.
- Sits in the multiplier library as the streaming, configurable successor to the fixed 8x8 combinational HA-array generators.

Parameters:
- WIDTH, 8, operand width; even, >= 4.
- APPROX_MASK, 7'b0010111, WIDTH-1 bits; bit i-1 set means column i (1..WIDTH-1) of array 0 is OR-only in approximate mode.
- NARR, WIDTH/2, derived, number of HA arrays (row pairs); not user-overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand handshake valid.
- in_ready  out  1  operand handshake ready.
- x  in  WIDTH  multiplicand (row selector).
- y  in  WIDTH  multiplier (column selector).
- approx_en  in  1  1 = apply APPROX_MASK to array 0 for this transaction; 0 = exact.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream ready.
- p  out  2*WIDTH  product.
- p_approx  out  1  approx_en of the transaction currently on p.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids = 0, out_valid = 0, p = 0, p_approx = 0, all data registers = 0. in_ready = 1 while out_valid = 0.
- Array k (k = 0..NARR-1): a_j = y[j]&x[2k], c_j = y[j]&x[2k+1].
  - t[0] = a_0.
  - Column i = 1..WIDTH-1: {cy_i, t[i]} = a_i + c_{i-1}.
  - b[i-1] = cy_i for i = 1..WIDTH-2; b[WIDTH-2] = c_{WIDTH-1}; t[WIDTH] = cy_{WIDTH-1}.
  - Array value V_k = sum t[i]*2^i + sum b[j]*2^(j+2), weighted by 2^(2k).
- Approximate column (k = 0, approx_en = 1, mask bit set): t[i] = a_i | c_{i-1}, cy_i = 0. Arrays 1..NARR-1 are always exact.
- Pipeline:
  - S1 registers all t/b arrays plus approx_en.
  - S2 registers pairwise sums of shifted V_k.
  - S3 registers the final sum into p.
- Latency: exactly 3 cycles from the accepted in_valid&in_ready edge to out_valid, with no stall.
- Throughput: 1 transaction per cycle when out_ready = 1.
- Flow control: stall = out_valid & ~out_ready.
  - When stalled, all stages hold and in_ready = 0.
  - Otherwise in_ready = 1 and bubbles advance.
  - p and p_approx are stable while out_valid & ~out_ready.
- No transaction is dropped or duplicated. Bubbles (invalid stages) never raise out_valid.
- Exact mode result: p == x*y for all inputs. Upper bits never truncate; the max result is (2^WIDTH-1)^2.
- Approximate error is non-negative: p <= x*y always.
- Reset mid-operation flushes all in-flight transactions; no out_valid follows reset release without a new accept.
- Simultaneous accept and output in the same cycle is legal and required at full rate.

Test Plan:
- WIDTH=8, approx_en=0, x=255, y=255 -> p=65025 after 3 cycles, p_approx=0.
- approx_en=1, x=255, y=255 -> p=64979.
- approx_en=1, x=3, y=3 -> p=7; same operands with approx_en=0 -> p=9.
- Stream 100 random exact transactions with out_ready toggled randomly -> outputs in order, each equal to x*y, p held stable during stalls, in_ready=0 exactly when stalled.
- Assert rst_n low with 3 transactions in flight -> out_valid=0 and p=0 immediately; after release, x=10, y=12 -> p=120, the only output seen.
- WIDTH=4, APPROX_MASK=3'b001, exhaustive 256 exact pairs -> p==x*y.
- WIDTH=4, APPROX_MASK=3'b001, approx pairs -> p<=x*y; x=3, y=1 -> p=3.
